mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store initiator that drives data port 2 (write port plus read port 2) of the CPU's 2048×32 synchronous data memory on behalf of the pipeline's memory stage. It accepts one request at a time over a valid/ready handshake, sequences the memory's registered-read timing, and returns load data over a valid/ready response channel with a holding register. With the RMW feature compiled in, it also performs byte-masked stores by read-modify-write.

## Interface
- No parameters. Address width is fixed at 11 bits and data width at 32 bits, matching the memory.
- clk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when both `req_valid` and `req_ready` are high; combinational.
- req_we  in  1  request type: 1 = store, 0 = load.
- req_addr  in  11  word address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i selects `req_wdata[8i+7:8i]`.
- resp_valid  out  1  load data valid.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load data.
- mem_w_en  out  1  memory write enable; registered.
- mem_w_adrs  out  11  memory write address; registered.
- mem_data_in  out  32  memory write data; registered.
- mem_r_en  out  1  memory read enable (port 2); registered.
- mem_r_adrs  out  11  memory read address (port 2); registered.
- mem_data_out  in  32  memory read data; valid the cycle after the memory samples `mem_r_en`.

## Operation
- States:
  - IDLE
  - RD_ISSUE
  - RD_DATA
  - RESP
  - RMW_ISSUE (RMW builds only)
  - RMW_DATA (RMW builds only)
- `req_ready` = (state==IDLE) || (state==RESP && resp_ready).
- Load accept:
  - Register `mem_r_en=1` and `mem_r_adrs=req_addr`.
  - Transitions: RD_ISSUE → RD_DATA → RESP.
- RD_DATA: `mem_r_en` is 0; `resp_rdata` <= `mem_data_out`; `resp_valid` <= 1.
- RESP:
  - Hold `resp_valid`/`resp_rdata` stable until `resp_ready`.
  - On handshake, clear `resp_valid`.
  - If a new request is accepted in the same cycle, take its IDLE transition directly; otherwise go to IDLE.
- Full store (`req_be`==4'hF, or any store in non-RMW builds):
  - Register `mem_w_en=1`, `mem_w_adrs`, `mem_data_in` for exactly one cycle.
  - State remains IDLE, so back-to-back stores proceed at one per cycle.
- Store with `req_be`==4'h0: accepted as a no-op with no memory activity.
- Partial store (RMW builds):
  - Latch addr/wdata/be.
  - Transitions: RMW_ISSUE (`mem_r_en`=1) → RMW_DATA.
  - In RMW_DATA, merge byte-wise: byte i comes from the latched wdata if be[i] is set, else from `mem_data_out`.
  - Register `mem_w_en=1` with the merged word, then go to IDLE.
- `mem_w_en`/`mem_r_en` are single-cycle pulses; they are never both high in the same cycle.
- Address/data outputs hold their last value when the enables are low.
- Ordering: a store write lands at the end of the cycle in which `mem_w_en` is high. A later load's `mem_r_en` is always at least one cycle after that, so there is no read-after-write hazard and no forwarding is needed.

## Timing
- Reset (`resetn`=0 at an edge), applied from any state:
  - state=IDLE.
  - `resp_valid`=0, `resp_rdata`=0.
  - `mem_w_en`=0, `mem_r_en`=0.
  - `mem_w_adrs`=0, `mem_r_adrs`=0, `mem_data_in`=0.
  - Outstanding load/RMW is dropped with no response and no write.
  - `req_ready` is 1 in the first cycle after reset.
- Load accepted in cycle N:
  - `mem_r_en` high in N+1.
  - Memory data valid in N+2.
  - `resp_valid` high from N+3.
- Load throughput is one per 3 cycles with `resp_ready` tied high.
- Store accepted in cycle N: `mem_w_en` high in N+1.
- Partial store accepted in cycle N:
  - `mem_r_en` in N+1.
  - Merge in N+2.
  - `mem_w_en` in N+3.
  - `req_ready` high again in N+3.
- Response backpressure is unbounded; no requests are accepted while RESP is stalled.
- `req_*` inputs are sampled only on the handshake; changes while `req_ready`=0 are ignored.

## Configuration
- `LSU_RMW_EN` defined:
  - RMW_ISSUE/RMW_DATA states exist.
  - Stores with `req_be`∉{4'h0, 4'hF} perform read-modify-write.
- `LSU_RMW_EN` undefined:
  - RMW states are not built.
  - `req_be` is ignored except for the 4'h0 no-op rule, which applies in both builds.
  - Every other store is a single-cycle full-word write.

## Test plan
- Reset then single store/load:
  - Stimulus: after reset, store addr 0x005 data 0xDEADBEEF be F, then load 0x005 with `resp_ready`=1.
  - Required: `mem_w_en` pulse 1 cycle after the store accept; `resp_rdata`=0xDEADBEEF exactly 3 cycles after the load accept.
- Back-to-back stores:
  - Stimulus: stores to 0x000..0x00F on consecutive cycles.
  - Required: `req_ready` stays 1; 16 consecutive `mem_w_en` pulses; reading back returns the stored values.
- Response backpressure:
  - Stimulus: load 0x7FF (holding 0x12345678) with `resp_ready`=0 for 5 cycles.
  - Required: `resp_valid`/`resp_rdata` stable and `req_ready`=0 throughout; on `resp_ready`=1, a simultaneous new load is accepted that cycle.
- RMW (`LSU_RMW_EN`):
  - Stimulus: word 0x11223344 at 0x010; store 0xAABBCCDD with be 4'b0101.
  - Required: the memory word becomes 0x11BB33DD; `mem_w_en` arrives 3 cycles after accept. Without the macro, the word becomes 0xAABBCCDD.
- be=0 store: no `mem_w_en` or `mem_r_en` pulse; memory is unchanged.
- Reset mid-load:
  - Stimulus: assert `resetn`=0 in the RD_DATA cycle.
  - Required: `resp_valid` never rises, all outputs return to 0, and `req_ready`=1 the cycle after release.

Source files
------------

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_if
// Brief    : Request/response channels and data-memory port 2 for mem_lsu.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        mem_w_en;
  logic [10:0] mem_w_adrs;
  logic [31:0] mem_data_in;
  logic        mem_r_en;
  logic [10:0] mem_r_adrs;
  logic [31:0] mem_data_out;

  // master is the environment: pipeline request/response plus memory read data
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_rdata,
           mem_w_en, mem_w_adrs, mem_data_in, mem_r_en, mem_r_adrs
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata,
           mem_w_en, mem_w_adrs, mem_data_in, mem_r_en, mem_r_adrs
  );
endinterface
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Brief    : Load/store initiator for data-memory port 2. Define LSU_RMW_EN to
//            build byte-masked stores as read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu (
  input  logic      clk,
  input  logic      resetn,
  mem_lsu_if.slave  bus
);

`ifdef LSU_RMW_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_ISSUE  = 3'd1,
    S_RD_DATA   = 3'd2,
    S_RESP      = 3'd3,
    S_RMW_ISSUE = 3'd4,
    S_RMW_DATA  = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_ISSUE = 2'd1,
    S_RD_DATA  = 2'd2,
    S_RESP     = 2'd3
  } state_t;
`endif

  localparam logic [3:0] c_BE_NONE = 4'h0;
  localparam logic [3:0] c_BE_FULL = 4'hF;

  state_t      r_state, w_nxt_state;
  logic        r_resp_valid, w_nxt_resp_valid;
  logic [31:0] r_resp_rdata, w_nxt_resp_rdata;
  logic        r_mem_w_en, w_nxt_w_en;
  logic [10:0] r_mem_w_adrs, w_nxt_w_adrs;
  logic [31:0] r_mem_data_in, w_nxt_data_in;
  logic        r_mem_r_en, w_nxt_r_en;
  logic [10:0] r_mem_r_adrs, w_nxt_r_adrs;
  logic        w_req_ready;
  logic        w_accept;
  logic        w_partial;

`ifdef LSU_RMW_EN
  logic [31:0] r_rmw_wdata, w_nxt_rmw_wdata;
  logic [3:0]  r_rmw_be, w_nxt_rmw_be;
  logic [31:0] w_merged;

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge_byte
    assign w_merged[8*gi +: 8] = r_rmw_be[gi] ? r_rmw_wdata[8*gi +: 8]
                                              : bus.mem_data_out[8*gi +: 8];
  end

  assign w_partial = (bus.req_be != c_BE_FULL);
`else
  assign w_partial = 1'b0;
`endif

  assign w_req_ready = (r_state == S_IDLE) || ((r_state == S_RESP) && bus.resp_ready);
  assign w_accept    = bus.req_valid && w_req_ready;

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_resp_valid = r_resp_valid;
    w_nxt_resp_rdata = r_resp_rdata;
    w_nxt_w_en       = 1'b0;
    w_nxt_w_adrs     = r_mem_w_adrs;
    w_nxt_data_in    = r_mem_data_in;
    w_nxt_r_en       = 1'b0;
    w_nxt_r_adrs     = r_mem_r_adrs;
`ifdef LSU_RMW_EN
    w_nxt_rmw_wdata  = r_rmw_wdata;
    w_nxt_rmw_be     = r_rmw_be;
`endif

    case (r_state)
      S_IDLE:     w_nxt_state = S_IDLE;
      S_RD_ISSUE: w_nxt_state = S_RD_DATA;
      S_RD_DATA: begin
        w_nxt_resp_rdata = bus.mem_data_out;
        w_nxt_resp_valid = 1'b1;
        w_nxt_state      = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_nxt_resp_valid = 1'b0;
          w_nxt_state      = S_IDLE;
        end
      end
`ifdef LSU_RMW_EN
      S_RMW_ISSUE: w_nxt_state = S_RMW_DATA;
      S_RMW_DATA: begin
        // the read address still holds the latched request address
        w_nxt_w_en    = 1'b1;
        w_nxt_w_adrs  = r_mem_r_adrs;
        w_nxt_data_in = w_merged;
        w_nxt_state   = S_IDLE;
      end
`endif
      default: w_nxt_state = S_IDLE;
    endcase

    // A request accepted out of RESP takes the same path as one out of IDLE
    if (w_accept) begin
      if (!bus.req_we) begin
        w_nxt_r_en   = 1'b1;
        w_nxt_r_adrs = bus.req_addr;
        w_nxt_state  = S_RD_ISSUE;
      end else if (bus.req_be == c_BE_NONE) begin
        w_nxt_w_en = 1'b0;
      end else if (w_partial) begin
`ifdef LSU_RMW_EN
        w_nxt_r_en      = 1'b1;
        w_nxt_r_adrs    = bus.req_addr;
        w_nxt_rmw_wdata = bus.req_wdata;
        w_nxt_rmw_be    = bus.req_be;
        w_nxt_state     = S_RMW_ISSUE;
`endif
      end else begin
        w_nxt_w_en    = 1'b1;
        w_nxt_w_adrs  = bus.req_addr;
        w_nxt_data_in = bus.req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= 32'h0;
      r_mem_w_en    <= 1'b0;
      r_mem_w_adrs  <= 11'h0;
      r_mem_data_in <= 32'h0;
      r_mem_r_en    <= 1'b0;
      r_mem_r_adrs  <= 11'h0;
`ifdef LSU_RMW_EN
      r_rmw_wdata   <= 32'h0;
      r_rmw_be      <= 4'h0;
`endif
    end else begin
      r_state       <= w_nxt_state;
      r_resp_valid  <= w_nxt_resp_valid;
      r_resp_rdata  <= w_nxt_resp_rdata;
      r_mem_w_en    <= w_nxt_w_en;
      r_mem_w_adrs  <= w_nxt_w_adrs;
      r_mem_data_in <= w_nxt_data_in;
      r_mem_r_en    <= w_nxt_r_en;
      r_mem_r_adrs  <= w_nxt_r_adrs;
`ifdef LSU_RMW_EN
      r_rmw_wdata   <= w_nxt_rmw_wdata;
      r_rmw_be      <= w_nxt_rmw_be;
`endif
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_rdata  = r_resp_rdata;
  assign bus.mem_w_en    = r_mem_w_en;
  assign bus.mem_w_adrs  = r_mem_w_adrs;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.mem_r_en    = r_mem_r_en;
  assign bus.mem_r_adrs  = r_mem_r_adrs;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu
// Brief    : Randomized self-checking bench for mem_lsu against a word-level
//            memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_lsu_if bus ();
  mem_lsu dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  // Synchronous 2048x32 memory: write lands at the edge, read data one cycle later
  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];
  logic [31:0] mem_q = 32'h0;
  assign bus.mem_data_out = mem_q;
  always @(posedge clk) begin
    if (bus.mem_w_en) mem[bus.mem_w_adrs] <= bus.mem_data_in;
    if (bus.mem_r_en) mem_q <= mem[bus.mem_r_adrs];
  end

  int n_checks   = 0;
  int n_errors   = 0;
  int n_wen      = 0;
  int last_waits = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) check_eq("w_r_exclusive", 32'(bus.mem_w_en & bus.mem_r_en), 32'h0);
    if (bus.mem_w_en) n_wen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte-lane semantics of a store as seen by the memory word
  function automatic logic [31:0] store_result(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] be);
    logic [3:0]  eff;
    logic [31:0] mask;
`ifdef LSU_RMW_EN
    eff = be;
`else
    eff = (be == 4'h0) ? 4'h0 : 4'hF;
`endif
    mask = {{8{eff[3]}}, {8{eff[2]}}, {8{eff[1]}}, {8{eff[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic bit is_partial(input logic [3:0] be);
`ifdef LSU_RMW_EN
    return (be != 4'h0) && (be != 4'hF);
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_ready();
    last_waits = 0;
    #1;
    while (!bus.req_ready) begin
      if (last_waits >= 50) begin
        check_eq("req_ready_timeout", 32'(bus.req_ready), 32'h1);
        return;
      end
      last_waits++;
      tick();
      #1;
    end
  endtask

  // Returns in the cycle right after acceptance (full/no-op) or in the write cycle (RMW)
  task automatic store_op(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] expw;
    expw = store_result(ref_mem[a], d, be);
    bus.req_valid = 1'b1; bus.req_we = 1'b1;
    bus.req_addr  = a;    bus.req_wdata = d; bus.req_be = be;
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    if (be == 4'h0) begin
      check_eq("nop_wen", 32'(bus.mem_w_en), 32'h0);
      check_eq("nop_ren", 32'(bus.mem_r_en), 32'h0);
    end else if (is_partial(be)) begin
      check_eq("rmw_ren",   32'(bus.mem_r_en),   32'h1);
      check_eq("rmw_radr",  32'(bus.mem_r_adrs), 32'(a));
      check_eq("rmw_wen_n1", 32'(bus.mem_w_en),  32'h0);
      tick();
      check_eq("rmw_ren_n2", 32'(bus.mem_r_en),  32'h0);
      check_eq("rmw_wen_n2", 32'(bus.mem_w_en),  32'h0);
      check_eq("rmw_busy",   32'(bus.req_ready), 32'h0);
      tick();
      check_eq("rmw_wen",   32'(bus.mem_w_en),   32'h1);
      check_eq("rmw_wadr",  32'(bus.mem_w_adrs), 32'(a));
      check_eq("rmw_wdata", bus.mem_data_in,     expw);
      check_eq("rmw_ready", 32'(bus.req_ready),  32'h1);
    end else begin
      check_eq("st_wen",   32'(bus.mem_w_en),   32'h1);
      check_eq("st_wadr",  32'(bus.mem_w_adrs), 32'(a));
      check_eq("st_wdata", bus.mem_data_in,     expw);
      check_eq("st_ren",   32'(bus.mem_r_en),   32'h0);
    end
    ref_mem[a] = expw;
  endtask

  // Returns in the cycle where the response handshake completes (resp_ready=1)
  task automatic load_op(input logic [10:0] a, input int stall);
    logic [31:0] expd;
    expd = ref_mem[a];
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a;
    bus.req_wdata = $urandom; bus.req_be = 4'($urandom);
    wait_ready();
    tick();
    bus.req_valid  = 1'b0;
    bus.resp_ready = (stall == 0);
    check_eq("ld_ren",      32'(bus.mem_r_en),   32'h1);
    check_eq("ld_radr",     32'(bus.mem_r_adrs), 32'(a));
    check_eq("ld_rv_clear", 32'(bus.resp_valid), 32'h0);
    tick();
    check_eq("ld_ren_pulse", 32'(bus.mem_r_en),   32'h0);
    check_eq("ld_rv_early",  32'(bus.resp_valid), 32'h0);
    tick();
    check_eq("ld_rvalid", 32'(bus.resp_valid), 32'h1);
    check_eq("ld_rdata",  bus.resp_rdata,      expd);
    for (int i = 0; i < stall; i++) begin
      #1;
      check_eq("bp_req_ready", 32'(bus.req_ready),  32'h0);
      check_eq("bp_rvalid",    32'(bus.resp_valid), 32'h1);
      check_eq("bp_rdata",     bus.resp_rdata,      expd);
      tick();
    end
    bus.resp_ready = 1'b1;
  endtask

  initial begin
    int base;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_be = '0;   bus.resp_ready = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end

    resetn = 1'b0;
    tick(); tick();
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_eq("rst_resp_rdata", bus.resp_rdata,      32'h0);
    check_eq("rst_w_en",       32'(bus.mem_w_en),   32'h0);
    check_eq("rst_r_en",       32'(bus.mem_r_en),   32'h0);
    check_eq("rst_w_adrs",     32'(bus.mem_w_adrs), 32'h0);
    check_eq("rst_r_adrs",     32'(bus.mem_r_adrs), 32'h0);
    check_eq("rst_data_in",    bus.mem_data_in,     32'h0);
    resetn = 1'b1;
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'h1);
    tick();

    // Single store then load
    store_op(11'h005, 32'hDEADBEEF, 4'hF);
    load_op(11'h005, 0);
    check_eq("t1_rdata", bus.resp_rdata, 32'hDEADBEEF);
    tick();

    // Back-to-back stores, then chained readback
    base = n_wen;
    for (int i = 0; i < 16; i++) begin
      store_op(11'(i), $urandom, 4'hF);
      if (i > 0) check_eq("b2b_no_wait", 32'(last_waits), 32'h0);
    end
    tick();
    check_eq("b2b_wen_count", 32'(n_wen - base), 32'd16);
    for (int i = 0; i < 16; i++) load_op(11'(i), 0);
    tick();

    // Response backpressure with a new load taken in the release cycle
    store_op(11'h7FF, 32'h12345678, 4'hF);
    tick();
    load_op(11'h7FF, 5);
    check_eq("bp_rdata_const", bus.resp_rdata, 32'h12345678);
    load_op(11'h005, 0);
    check_eq("bp_chain_accept", 32'(last_waits), 32'h0);
    tick();

    // Byte-masked store
    store_op(11'h010, 32'h11223344, 4'hF);
    store_op(11'h010, 32'hAABBCCDD, 4'b0101);
    tick();
    load_op(11'h010, 0);
`ifdef LSU_RMW_EN
    check_eq("rmw_word", bus.resp_rdata, 32'h11BB33DD);
`else
    check_eq("rmw_word", bus.resp_rdata, 32'hAABBCCDD);
`endif
    tick();

    // be=0 store leaves memory untouched
    store_op(11'h010, 32'hFFFFFFFF, 4'h0);
    tick();
    check_eq("nop_ren_later", 32'(bus.mem_r_en), 32'h0);
    check_eq("nop_wen_later", 32'(bus.mem_w_en), 32'h0);
    load_op(11'h010, 0);
    tick();

    // Reset during RD_DATA
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 11'h7FF;
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    check_eq("mr_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_eq("mr_resp_rdata", bus.resp_rdata,      32'h0);
    check_eq("mr_r_en",       32'(bus.mem_r_en),   32'h0);
    check_eq("mr_r_adrs",     32'(bus.mem_r_adrs), 32'h0);
    check_eq("mr_w_adrs",     32'(bus.mem_w_adrs), 32'h0);
    check_eq("mr_data_in",    bus.mem_data_in,     32'h0);
    resetn = 1'b1;
    tick();
    check_eq("mr_req_ready", 32'(bus.req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check_eq("mr_no_resp", 32'(bus.resp_valid), 32'h0);
      tick();
    end

    // Randomized mix
    for (int n = 0; n < 200; n++) begin
      logic [10:0] a;
      int kind;
      a = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'(16 + $urandom_range(0, 15));
      kind = $urandom_range(0, 3);
      if (kind == 0)
        load_op(a, $urandom_range(0, 2));
      else if (kind == 3)
        tick();
      else
        store_op(a, $urandom, 4'($urandom_range(0, 15)));
    end
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
